// File: rtl/bf16_to_fp32_pipe.sv
// bf16_to_fp32_pipe: two-stage BF16->FP32 widening converter (classify, assemble) with valid/ready and sticky fpcsr.
// Define BF16_DAZ_EN to flush subnormal inputs to signed zero and raise UF.
module bf16_to_fp32_pipe #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] operand_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  out_flags,
    input  logic        flags_clr,
    output logic [3:0]  fpcsr
);
`ifdef BF16_DAZ_EN
    localparam logic DAZ = 1'b1;
`else
    localparam logic DAZ = 1'b0;
`endif
    logic        s1_valid, s1_sign;
    logic [7:0]  s1_exp;
    logic [6:0]  s1_man;
    logic [5:0]  s1_class;
    logic        adv1, adv2, out_fire, exp_max, exp_min, man_nz, is_nan, is_daz;
    logic [5:0]  cls;
    logic [31:0] asm_result;
    logic [3:0]  asm_flags;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign out_fire = out_valid && out_ready;

    assign exp_max = &operand_a[14:7];
    assign exp_min = ~|operand_a[14:7];
    assign man_nz  = |operand_a[6:0];
    // one-hot {zero, sub, norm, inf, qnan, snan}
    assign cls = {exp_min & ~man_nz, exp_min & man_nz, ~exp_min & ~exp_max,
                  exp_max & ~man_nz, exp_max & man_nz & operand_a[6], exp_max & man_nz & ~operand_a[6]};

    assign is_nan     = |s1_class[1:0];
    assign is_daz     = DAZ && s1_class[4];
    assign asm_result = is_nan ? CANON_NAN :
                        is_daz ? {s1_sign, 31'h0} :
                        |s1_class[5:2] ? {s1_sign, s1_exp, s1_man, 16'h0000} : 32'h0;
    assign asm_flags  = {s1_class[0], 1'b0, is_daz, 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= 8'h00;
            s1_man   <= 7'h00;
            s1_class <= 6'h00;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= operand_a[15];
                s1_exp   <= operand_a[14:7];
                s1_man   <= operand_a[6:0];
                s1_class <= cls;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= 32'h0;
            out_flags <= 4'h0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result    <= asm_result;
                out_flags <= asm_flags;
            end
        end
    end

    // clear takes priority, then the flags of a simultaneous transfer are merged in
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fpcsr <= 4'h0;
        else if (flags_clr)
            fpcsr <= out_fire ? out_flags : 4'h0;
        else if (out_fire)
            fpcsr <= fpcsr | out_flags;
    end
endmodule

// File: tb/tb_bf16_to_fp32_pipe.sv
// tb_bf16_to_fp32_pipe: directed and randomized checks of bf16_to_fp32_pipe against a behavioural model.
// Honours BF16_DAZ_EN the same way as the design.
module tb_bf16_to_fp32_pipe;
`ifdef BF16_DAZ_EN
    localparam bit DAZ = 1'b1;
`else
    localparam bit DAZ = 1'b0;
`endif
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0, flags_clr = 0;
    logic        in_ready, out_valid;
    logic [15:0] operand_a = 0;
    logic [31:0] result;
    logic [3:0]  out_flags, fpcsr;
    int tests = 0, fails = 0;

    bf16_to_fp32_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .operand_a(operand_a),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_flags(out_flags),
        .flags_clr(flags_clr), .fpcsr(fpcsr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // returns {flags, result}
    function automatic logic [35:0] model(input logic [15:0] a);
        logic [7:0] e = a[14:7];
        logic [6:0] m = a[6:0];
        if (e == 8'hFF && m != 0) return {(m[6] ? 4'h0 : 4'h8), 32'h7FC0_0000};
        if (DAZ && e == 0 && m != 0) return {4'h2, a[15], 31'h0};
        return {4'h0, a, 16'h0000};
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0: return {s, 15'h0};
            1: return {s, 8'h00, 7'($urandom_range(1, 127))};
            2: return {s, 8'hFF, 7'h00};
            3: return {s, 8'hFF, 1'b1, 6'($urandom)};
            4: return {s, 8'hFF, 1'b0, 6'($urandom_range(1, 63))};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 0;
        out_ready = 1;
        repeat (3) tick();
        flags_clr = 1;
        tick();
        flags_clr = 0;
    endtask

    task automatic test_reset();
        tick();
        tests++;
        if ({out_valid, result, out_flags, fpcsr, in_ready} !== {1'b0, 32'h0, 4'h0, 4'h0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state got v=%b r=%h f=%h csr=%h rdy=%b exp v=0 r=0 f=0 csr=0 rdy=1",
                     out_valid, result, out_flags, fpcsr, in_ready);
        end
        tick();
        reset = 0;
        tick();
        tests++;
        if (in_ready !== 1 || out_valid !== 0) begin
            fails++;
            $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] v[3] = '{16'h3F80, 16'hC000, 16'h7F80};
        logic [31:0] e[3] = '{32'h3F80_0000, 32'hC000_0000, 32'h7F80_0000};
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = i < 3;
            operand_a = v[i % 3];
            tick();
            if (i == 0) begin
                tests++;
                if (out_valid !== 0) begin
                    fails++;
                    $display("FAIL basic_latency got v=%b exp v=0", out_valid);
                end
            end else if (i <= 3) begin
                tests++;
                if (out_valid !== 1 || result !== e[i-1] || out_flags !== 0) begin
                    fails++;
                    $display("FAIL basic_%0d got v=%b r=%h f=%h exp v=1 r=%h f=0", i - 1, out_valid, result, out_flags, e[i-1]);
                end
            end
        end
        in_valid = 0;
    endtask

    task automatic test_nan();
        logic [15:0] v[2] = '{16'h7FC1, 16'hFF81};
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = i < 2;
            operand_a = v[i % 2];
            tick();
            if (i == 1 || i == 2) begin
                tests++;
                if (out_valid !== 1 || result !== 32'h7FC0_0000 || out_flags !== (i == 2 ? 4'h8 : 4'h0)) begin
                    fails++;
                    $display("FAIL nan_%0d got v=%b r=%h f=%h exp v=1 r=7fc00000 f=%h", i, out_valid, result, out_flags,
                             (i == 2 ? 4'h8 : 4'h0));
                end
            end
        end
        in_valid = 0;
        tests++;
        if (fpcsr !== 4'h8) begin
            fails++;
            $display("FAIL nan_fpcsr got %h exp 8", fpcsr);
        end
        repeat (3) tick();
        tests++;
        if (fpcsr !== 4'h8) begin
            fails++;
            $display("FAIL nan_fpcsr_sticky got %h exp 8", fpcsr);
        end
    endtask

    task automatic test_flags_clr();
        out_ready = 0;
        in_valid = 1;
        operand_a = 16'hFF81;
        tick();
        in_valid = 0;
        tick();
        tests++;
        if (out_valid !== 1 || fpcsr !== 4'h8) begin
            fails++;
            $display("FAIL clr_setup got v=%b csr=%h exp v=1 csr=8", out_valid, fpcsr);
        end
        out_ready = 1;
        flags_clr = 1;
        tick();
        tests++;
        if (fpcsr !== 4'h8) begin
            fails++;
            $display("FAIL clr_with_snan got %h exp 8", fpcsr);
        end
        tick();
        flags_clr = 0;
        tests++;
        if (fpcsr !== 4'h0) begin
            fails++;
            $display("FAIL clr_alone got %h exp 0", fpcsr);
        end
        out_ready = 0;
        in_valid = 1;
        operand_a = 16'hFF81;
        tick();
        operand_a = 16'h3F80;
        tick();
        in_valid = 0;
        out_ready = 1;
        tick();
        tests++;
        if (fpcsr !== 4'h8) begin
            fails++;
            $display("FAIL clr_resnan got %h exp 8", fpcsr);
        end
        flags_clr = 1;
        tick();
        flags_clr = 0;
        tests++;
        if (fpcsr !== 4'h0) begin
            fails++;
            $display("FAIL clr_with_norm got %h exp 0", fpcsr);
        end
    endtask

    task automatic test_sub();
        logic [35:0] m = model(16'h8001);
        out_ready = 1;
        in_valid = 1;
        operand_a = 16'h8001;
        tick();
        in_valid = 0;
        tick();
        tests++;
        if (out_valid !== 1 || result !== m[31:0] || out_flags !== m[35:32]) begin
            fails++;
            $display("FAIL sub got v=%b r=%h f=%h exp v=1 r=%h f=%h", out_valid, result, out_flags, m[31:0], m[35:32]);
        end
        tick();
        tests++;
        if (fpcsr !== m[35:32]) begin
            fails++;
            $display("FAIL sub_fpcsr got %h exp %h", fpcsr, m[35:32]);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] vals[4];
        logic [15:0] q[$];
        logic [35:0] m, m0;
        int sent = 0, got = 0;
        foreach (vals[i]) vals[i] = rand_bf16();
        m0 = model(vals[0]);
        for (int c = 0; c < 20 && got < 4; c++) begin
            out_ready = c >= 5;
            in_valid = sent < 4;
            operand_a = vals[sent % 4];
            #1;
            if (c < 5) begin
                tests++;
                if (in_ready !== (c < 2)) begin
                    fails++;
                    $display("FAIL bp_in_ready_c%0d got %b exp %b", c, in_ready, c < 2);
                end
            end
            if (c >= 2 && c < 5) begin
                tests++;
                if (out_valid !== 1 || result !== m0[31:0]) begin
                    fails++;
                    $display("FAIL bp_hold_c%0d got v=%b r=%h exp v=1 r=%h", c, out_valid, result, m0[31:0]);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra got r=%h exp no output", result);
                end else begin
                    m = model(q.pop_front());
                    if (result !== m[31:0] || out_flags !== m[35:32]) begin
                        fails++;
                        $display("FAIL bp_out_%0d got r=%h f=%h exp r=%h f=%h", got, result, out_flags, m[31:0], m[35:32]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(operand_a);
                sent++;
            end
            tick();
        end
        tests++;
        if (got != 4 || sent != 4 || out_valid !== 0) begin
            fails++;
            $display("FAIL bp_count got sent=%0d out=%0d v=%b exp sent=4 out=4 v=0", sent, got, out_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [35:0] m;
        logic [3:0] mfp = 0, f;
        logic hold = 0, fire;
        int sent = 0, got = 0;
        const int n = 200;
        for (int c = 0; c < 4000 && got < n; c++) begin
            if (!hold) begin
                in_valid = sent < n && $urandom_range(0, 3) != 0;
                operand_a = rand_bf16();
            end
            out_ready = $urandom_range(0, 2) != 0;
            flags_clr = $urandom_range(0, 9) == 0;
            #1;
            fire = out_valid && out_ready;
            f = 0;
            if (fire) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra got r=%h exp no output", result);
                end else begin
                    m = model(q.pop_front());
                    f = m[35:32];
                    if (result !== m[31:0] || out_flags !== f) begin
                        fails++;
                        $display("FAIL rand_out_%0d got r=%h f=%h exp r=%h f=%h", got, result, out_flags, m[31:0], f);
                    end
                end
                got++;
            end
            mfp = flags_clr ? f : (mfp | f);
            hold = in_valid && !in_ready;
            if (in_valid && in_ready) begin
                q.push_back(operand_a);
                sent++;
            end
            tick();
            tests++;
            if (fpcsr !== mfp) begin
                fails++;
                $display("FAIL rand_fpcsr_c%0d got %h exp %h", c, fpcsr, mfp);
            end
        end
        flags_clr = 0;
        in_valid = 0;
        tests++;
        if (got != n) begin
            fails++;
            $display("FAIL rand_count got %0d exp %0d", got, n);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1;
        in_valid = 1;
        operand_a = 16'hFF81;
        tick();
        in_valid = 0;
        repeat (2) tick();
        out_ready = 0;
        in_valid = 1;
        operand_a = 16'h3F80;
        tick();
        operand_a = 16'h4000;
        tick();
        in_valid = 0;
        #1;
        tests++;
        if (out_valid !== 1 || in_ready !== 0 || fpcsr !== 4'h8) begin
            fails++;
            $display("FAIL full_stall got v=%b rdy=%b csr=%h exp v=1 rdy=0 csr=8", out_valid, in_ready, fpcsr);
        end
        reset = 1;
        #1;
        tests++;
        if ({out_valid, result, out_flags, fpcsr} !== 41'h0) begin
            fails++;
            $display("FAIL mid_reset got v=%b r=%h f=%h csr=%h exp all 0", out_valid, result, out_flags, fpcsr);
        end
        tick();
        reset = 0;
        #1;
        tests++;
        if (in_ready !== 1 || out_valid !== 0) begin
            fails++;
            $display("FAIL mid_reset_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        out_ready = 1;
        in_valid = 1;
        operand_a = 16'h4049;
        tick();
        in_valid = 0;
        tests++;
        if (out_valid !== 0) begin
            fails++;
            $display("FAIL restart_early got v=%b exp 0", out_valid);
        end
        tick();
        tests++;
        if (out_valid !== 1 || result !== 32'h4049_0000) begin
            fails++;
            $display("FAIL restart_out got v=%b r=%h exp v=1 r=40490000", out_valid, result);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        drain();
        test_nan();
        test_flags_clr();
        drain();
        test_sub();
        drain();
        test_backpressure();
        drain();
        test_random();
        drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
